// File: rtl/reg_writeback.sv
// Writeback buffer in front of the register file: queues execute results and
// serializes up to two destination writes per result onto the single regw port.
module reg_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_en1,
  input  logic [AW-1:0] in_addr1,
  input  logic [DW-1:0] in_data1,
  input  logic [1:0]    in_en2,
  input  logic [AW-1:0] in_addr2,
  input  logic [DW-1:0] in_data2,
  output logic [1:0]    regw_enable,
  output logic [AW-1:0] regw_addr,
  output logic [DW-1:0] regw_data,
  input  logic [1:0]    chk_src,
  input  logic [AW-1:0] chk_addr,
  output logic          chk_hit,
  output logic          busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [1:0]    en1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data1;
    logic [1:0]    en2;
    logic [AW-1:0] addr2;
    logic [DW-1:0] data2;
  } entry_t;

  typedef enum logic {ISSUE1, ISSUE2} slot_e;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  slot_e         slot;

  entry_t        in_entry;
  entry_t        head;
  logic          head_valid;
  logic          accept;
  logic          pop;
  logic          push;
  logic          fifo_pop;
  slot_e         next_slot;
  logic [1:0]    issue_en;
  logic [AW-1:0] issue_addr;
  logic [DW-1:0] issue_data;

  assign in_entry = '{en1: in_en1, addr1: in_addr1, data1: in_data1,
                      en2: in_en2, addr2: in_addr2, data2: in_data2};

  assign in_ready   = (count < CW'(DEPTH));
  assign accept     = in_valid & in_ready;
  assign busy       = (count != '0) || (regw_enable != 2'b00);

  // With an empty buffer the entry arriving on this edge is issued directly.
  assign head       = (count != '0) ? mem[rd_ptr] : in_entry;
  assign head_valid = (count != '0) || accept;

  always_comb begin
    issue_en   = 2'b00;
    issue_addr = '0;
    issue_data = '0;
    pop        = 1'b0;
    next_slot  = slot;
    if (head_valid) begin
      if (slot == ISSUE1 && head.en1 != 2'b00) begin
        issue_en   = head.en1;
        issue_addr = head.addr1;
        issue_data = head.data1;
        if (head.en2 != 2'b00) begin
          next_slot = ISSUE2;
        end else begin
          pop = 1'b1;
        end
      end else begin
        // Covers ISSUE2 and entries whose first slot is empty; en2 may also
        // be empty, in which case the entry retires with no write this cycle.
        issue_en   = head.en2;
        issue_addr = head.addr2;
        issue_data = head.data2;
        pop        = 1'b1;
        next_slot  = ISSUE1;
      end
    end
  end

  // A bypassed entry that fully retires on its arrival edge never occupies storage.
  assign push     = accept && !((count == '0) && pop);
  assign fifo_pop = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      slot   <= ISSUE1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, fifo_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      slot <= next_slot;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regw_enable <= 2'b00;
      regw_addr   <= '0;
      regw_data   <= '0;
    end else begin
      regw_enable <= issue_en;
      if (issue_en != 2'b00) begin
        regw_addr <= issue_addr;
        regw_data <= issue_data;
      end
    end
  end

  logic [DEPTH-1:0] occupied;
  logic [DEPTH-1:0] slot1_done;

  always_comb begin
    occupied   = '0;
    slot1_done = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied[i]   = {1'b0, PW'(i) - rd_ptr} < count;
      slot1_done[i] = (PW'(i) == rd_ptr) && (slot == ISSUE2);
    end
  end

  // The head's first slot, once issued, is represented by the regw output itself.
  always_comb begin
    chk_hit = ((regw_enable & chk_src) != 2'b00) && (regw_addr == chk_addr);
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied[i]) begin
        if (!slot1_done[i] && ((mem[i].en1 & chk_src) != 2'b00) &&
            (mem[i].addr1 == chk_addr)) begin
          chk_hit = 1'b1;
        end
        if (((mem[i].en2 & chk_src) != 2'b00) && (mem[i].addr2 == chk_addr)) begin
          chk_hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: expected writes are queued as results are
// accepted and a negedge monitor matches every regw write against them in order.
module tb_reg_writeback;

  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int DW    = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_en1;
  logic [AW-1:0] in_addr1;
  logic [DW-1:0] in_data1;
  logic [1:0]    in_en2;
  logic [AW-1:0] in_addr2;
  logic [DW-1:0] in_data2;
  logic [1:0]    regw_enable;
  logic [AW-1:0] regw_addr;
  logic [DW-1:0] regw_data;
  logic [1:0]    chk_src;
  logic [AW-1:0] chk_addr;
  logic          chk_hit;
  logic          busy;

  typedef struct {
    logic [1:0]    en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  writes_seen = 0;
  bit  ready_low_seen = 0;

  reg_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_en1(in_en1), .in_addr1(in_addr1), .in_data1(in_data1),
    .in_en2(in_en2), .in_addr2(in_addr2), .in_data2(in_data2),
    .regw_enable(regw_enable), .regw_addr(regw_addr), .regw_data(regw_data),
    .chk_src(chk_src), .chk_addr(chk_addr), .chk_hit(chk_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Every write on regw must be the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!reset && regw_enable != 2'b00) begin
      wr_t exp_w;
      writes_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got en=%b addr=%h data=%h, required no write",
                 regw_enable, regw_addr, regw_data);
      end else begin
        exp_w = sb.pop_front();
        if (regw_enable != exp_w.en || regw_addr != exp_w.addr || regw_data != exp_w.data) begin
          errors++;
          $display("[TB] FAIL regw_write#%0d: got en=%b addr=%h data=%h, required en=%b addr=%h data=%h",
                   writes_seen, regw_enable, regw_addr, regw_data, exp_w.en, exp_w.addr, exp_w.data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] e1, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d1, input logic [1:0] e2,
                               input logic [AW-1:0] a2, input logic [DW-1:0] d2);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_en1 = e1; in_addr1 = a1; in_data1 = d1;
    in_en2 = e2; in_addr2 = a2; in_data2 = d2;
    #1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      ready_low_seen = 1;
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0, required 1 within 200 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (e1 != 2'b00) sb.push_back('{e1, a1, d1});
    if (e2 != 2'b00) sb.push_back('{e2, a2, d2});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int guard = 0;
    while ((busy || sb.size() != 0) && guard < 500) begin
      @(negedge clk);
      #2;
      guard++;
    end
    checkOutput({name, "_drained"}, 64'(busy || sb.size() != 0), 64'd0);
  endtask

  initial begin
    int w0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_en1 = '0; in_addr1 = '0; in_data1 = '0;
    in_en2 = '0; in_addr2 = '0; in_data2 = '0;
    chk_src = 2'b11; chk_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_enable", 64'(regw_enable), 64'd0);
    checkOutput("rst_addr", 64'(regw_addr), 64'd0);
    checkOutput("rst_data", regw_data, 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_chk_hit", 64'(chk_hit), 64'd0);
    reset = 1'b0;

    // Single write appears one cycle after acceptance, then the port idles.
    applyStimulus(2'b01, 8'h05, 64'h1234, 2'b00, 8'h00, 64'h0);
    @(negedge clk); #2;
    checkOutput("t1_enable", 64'(regw_enable), 64'd1);
    checkOutput("t1_addr", 64'(regw_addr), 64'h05);
    checkOutput("t1_data", regw_data, 64'h1234);
    @(negedge clk); #2;
    checkOutput("t1_idle_enable", 64'(regw_enable), 64'd0);
    checkOutput("t1_idle_busy", 64'(busy), 64'd0);

    // Dual destinations are serialized on consecutive cycles.
    applyStimulus(2'b10, 8'h20, 64'hAA, 2'b01, 8'h04, 64'hBB);
    @(negedge clk); #2;
    checkOutput("t2_first_enable", 64'(regw_enable), 64'd2);
    checkOutput("t2_first_addr", 64'(regw_addr), 64'h20);
    @(negedge clk); #2;
    checkOutput("t2_second_enable", 64'(regw_enable), 64'd1);
    checkOutput("t2_second_addr", 64'(regw_addr), 64'h04);
    waitIdle("t2");

    // Back-to-back dual results overrun the buffer and must stall the producer.
    w0 = writes_seen;
    ready_low_seen = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'b01, 8'(8'h40 + 2 * i), {32'hC0DE0000, 32'(i)},
                    2'b10, 8'(8'h41 + 2 * i), {32'hBEEF0000, 32'(i)});
    end
    waitIdle("t3");
    checkOutput("t3_write_count", 64'(writes_seen - w0), 64'd16);
    checkOutput("t3_ready_low_seen", 64'(ready_low_seen), 64'd1);

    // A result with no destinations costs one idle issue cycle.
    applyStimulus(2'b01, 8'h11, 64'h111, 2'b00, 8'h00, 64'h0);
    applyStimulus(2'b00, 8'h22, 64'h222, 2'b00, 8'h33, 64'h333);
    applyStimulus(2'b10, 8'h44, 64'h444, 2'b00, 8'h00, 64'h0);
    @(negedge clk); #2;
    checkOutput("t4_third_enable", 64'(regw_enable), 64'd2);
    checkOutput("t4_third_addr", 64'(regw_addr), 64'h44);
    waitIdle("t4");

    // Hazard: the local write to 0x30 is visible while buffered and while on regw.
    applyStimulus(2'b01, 8'h10, 64'h1, 2'b01, 8'h11, 64'h2);
    applyStimulus(2'b10, 8'h30, 64'h30, 2'b00, 8'h00, 64'h0);
    @(negedge clk);
    chk_src = 2'b10; chk_addr = 8'h30; #2;
    checkOutput("t5_buffered_hit", 64'(chk_hit), 64'd1);
    chk_src = 2'b01; #1;
    checkOutput("t5_wrong_bank", 64'(chk_hit), 64'd0);
    @(negedge clk);
    chk_src = 2'b10; #2;
    checkOutput("t5_inflight_hit", 64'(chk_hit), 64'd1);
    @(negedge clk); #2;
    checkOutput("t5_after_hit", 64'(chk_hit), 64'd0);
    waitIdle("t5");

    // Randomized traffic with gaps; the monitor checks every write.
    w0 = writes_seen;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      applyStimulus(2'($urandom), 8'($urandom_range(0, 15)), {$urandom, $urandom},
                    2'($urandom), 8'($urandom_range(0, 15)), {$urandom, $urandom});
    end
    waitIdle("rand");

    // Reset in the middle of a drain discards everything.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b11, 8'(8'h60 + i), 64'(i), 2'b01, 8'(8'h70 + i), 64'(i + 100));
    end
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    sb.delete();
    chk_src = 2'b11; chk_addr = 8'h70;
    checkOutput("t6_enable", 64'(regw_enable), 64'd0);
    checkOutput("t6_busy", 64'(busy), 64'd0);
    checkOutput("t6_in_ready", 64'(in_ready), 64'd1);
    checkOutput("t6_chk_hit", 64'(chk_hit), 64'd0);
    w0 = writes_seen;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    #2;
    checkOutput("t6_no_writes", 64'(writes_seen - w0), 64'd0);
    checkOutput("t6_busy_after", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
